// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RISC-V immediate generator behind a valid/ready stage (rev 1.0).
// Optional opcode-driven AUTO decode: define IMM_DECODE_AUTO_EN.
`default_nettype none

module imm_decode_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [2:0]      in_type,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [31:0]     out_inst,
  output logic            out_illegal
);

  localparam logic [2:0] c_T_U    = 3'd0;
  localparam logic [2:0] c_T_J    = 3'd1;
  localparam logic [2:0] c_T_I    = 3'd2;
  localparam logic [2:0] c_T_S    = 3'd3;
  localparam logic [2:0] c_T_B    = 3'd4;
  localparam logic [2:0] c_T_Z    = 3'd5;
  localparam logic [2:0] c_T_SH   = 3'd6;
  localparam logic [2:0] c_T_AUTO = 3'd7;

  logic [2:0]      w_fmt;
  logic            w_ill;
  logic [XLEN-1:0] w_imm;
  logic            w_acc;
  logic            w_main_free;

  logic            r_main_v;
  logic [XLEN-1:0] r_main_imm;
  logic [31:0]     r_main_inst;
  logic            r_main_ill;
  logic            r_skid_v;
  logic [XLEN-1:0] r_skid_imm;
  logic [31:0]     r_skid_inst;
  logic            r_skid_ill;
  logic            r_in_ready;

  always_comb begin
    w_fmt = in_type;
    w_ill = 1'b0;
`ifdef IMM_DECODE_AUTO_EN
    if (in_type == c_T_AUTO) begin
      w_fmt = c_T_I;
      case (in_inst[6:0])
        7'b0110111, 7'b0010111:             w_fmt = c_T_U;
        7'b1101111:                         w_fmt = c_T_J;
        7'b1100111, 7'b0000011, 7'b1110011: w_fmt = c_T_I;
        // funct3 001/101 are the shift-immediate encodings
        7'b0010011: if (in_inst[13:12] == 2'b01) w_fmt = c_T_SH;
        7'b0011011: w_ill = (XLEN != 64);
        7'b0100011:                         w_fmt = c_T_S;
        7'b1100011:                         w_fmt = c_T_B;
        default:                            w_ill = 1'b1;
      endcase
    end
`else
    if (in_type == c_T_AUTO) w_fmt = c_T_I;
`endif
  end

  always_comb begin
    case (w_fmt)
      c_T_U:   w_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      c_T_J:   w_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                      in_inst[30:21], 1'b0}));
      c_T_S:   w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      c_T_B:   w_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                      in_inst[11:8], 1'b0}));
      c_T_Z:   w_imm = XLEN'(in_inst[19:15]);
      c_T_SH:  w_imm = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
      default: w_imm = XLEN'($signed(in_inst[31:20]));
    endcase
    if (w_ill) w_imm = '0;
  end

  assign w_main_free = !r_main_v || out_ready;
  assign in_ready    = (SKID != 0) ? r_in_ready : w_main_free;
  assign w_acc       = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v    <= 1'b0;
      r_main_imm  <= '0;
      r_main_inst <= '0;
      r_main_ill  <= 1'b0;
      r_skid_v    <= 1'b0;
      r_skid_imm  <= '0;
      r_skid_inst <= '0;
      r_skid_ill  <= 1'b0;
      r_in_ready  <= 1'b0;
    end else if (flush) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_main_free) begin
        // a parked beat is older than anything arriving now, so it goes first
        if (r_skid_v) begin
          r_main_v    <= 1'b1;
          r_main_imm  <= r_skid_imm;
          r_main_inst <= r_skid_inst;
          r_main_ill  <= r_skid_ill;
        end else if (w_acc) begin
          r_main_v    <= 1'b1;
          r_main_imm  <= w_imm;
          r_main_inst <= in_inst;
          r_main_ill  <= w_ill;
        end else begin
          r_main_v <= 1'b0;
        end
        r_skid_v <= 1'b0;
      end else if (w_acc && (SKID != 0)) begin
        r_skid_v    <= 1'b1;
        r_skid_imm  <= w_imm;
        r_skid_inst <= in_inst;
        r_skid_ill  <= w_ill;
      end
      r_in_ready <= w_main_free || !(r_skid_v || w_acc);
    end
  end

  assign out_valid   = r_main_v;
  assign out_imm     = r_main_imm;
  assign out_inst    = r_main_inst;
  assign out_illegal = r_main_ill;

endmodule

`default_nettype wire
